// File: rtl/seg_scan.sv
// Five-digit multiplexed seven-segment scanner with frame-synchronous data
// updates, per-slot anti-ghost blanking, and flash/blank display modes.
module seg_scan #(
    parameter int DIGIT_TICKS  = 1000,
    parameter int BLANK_TICKS  = 2,
    parameter int FLASH_FRAMES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_tick,
    input  logic [39:0] data_in,
    input  logic        data_load,
    input  logic [2:0]  seg_mode,
    output logic [4:0]  digit_sel,
    output logic [7:0]  seg_out,
    output logic [2:0]  flash_cnt,
    output logic        frame_start
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [TW-1:0] BLANK_END  = TW'(BLANK_TICKS);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_FLASH = 2'd1,
        MODE_BLANK = 2'd2
    } mode_t;

    // Unused mode codes collapse onto constant so they never look like a mode change.
    function automatic mode_t norm_mode(input logic [2:0] code);
        case (code)
            3'd1:    norm_mode = MODE_FLASH;
            3'd2:    norm_mode = MODE_BLANK;
            default: norm_mode = MODE_CONST;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(input logic [39:0] data, input logic [2:0] idx);
        case (idx)
            3'd0:    pick_byte = data[39:32];
            3'd1:    pick_byte = data[31:24];
            3'd2:    pick_byte = data[23:16];
            3'd3:    pick_byte = data[15:8];
            3'd4:    pick_byte = data[7:0];
            default: pick_byte = 8'h00;
        endcase
    endfunction

    logic          running_r, running_s;
    logic [TW-1:0] tick_r, tick_s;
    logic [2:0]    idx_r, idx_s;
    logic          boundary_s;
    logic [39:0]   pend_data_r, pend_data_s;
    mode_t         pend_mode_r, pend_mode_s;
    logic [39:0]   act_data_r, act_data_s;
    mode_t         act_mode_r, act_mode_s;
    logic          phase_on_r, phase_on_s;
    logic [FW-1:0] frame_r, frame_s;
    logic [2:0]    flash_cnt_s;
    logic [4:0]    digit_sel_s;
    logic [7:0]    seg_out_s;

    // Scan position: the first tick after reset only enables digit 0.
    always_comb begin
        running_s  = running_r;
        tick_s     = tick_r;
        idx_s      = idx_r;
        boundary_s = 1'b0;
        if (scan_tick) begin
            if (!running_r) begin
                running_s = 1'b1;
            end else if (tick_r == TICK_LAST) begin
                tick_s = '0;
                if (idx_r == 3'd4) begin
                    idx_s      = 3'd0;
                    boundary_s = 1'b1;
                end else begin
                    idx_s = idx_r + 3'd1;
                end
            end else begin
                tick_s = tick_r + TICK_ONE;
            end
        end else begin
            running_s = running_r;
        end
    end

    // Pending capture and frame-boundary copy; a coincident load goes straight through.
    always_comb begin
        pend_data_s = data_load ? data_in : pend_data_r;
        pend_mode_s = data_load ? norm_mode(seg_mode) : pend_mode_r;
        act_data_s  = boundary_s ? pend_data_s : act_data_r;
        act_mode_s  = boundary_s ? pend_mode_s : act_mode_r;
    end

    // Flash phase, frame counter and completed-cycle count.
    always_comb begin
        phase_on_s  = phase_on_r;
        frame_s     = frame_r;
        flash_cnt_s = flash_cnt;
        if (boundary_s && (act_mode_s != act_mode_r)) begin
            phase_on_s  = 1'b1;
            frame_s     = '0;
            flash_cnt_s = 3'd0;
        end else if (act_mode_r == MODE_FLASH) begin
            if (boundary_s) begin
                if (frame_r == FRAME_LAST) begin
                    frame_s    = '0;
                    phase_on_s = ~phase_on_r;
                    if (!phase_on_r && (flash_cnt != 3'd7)) begin
                        flash_cnt_s = flash_cnt + 3'd1;
                    end else begin
                        flash_cnt_s = flash_cnt;
                    end
                end else begin
                    frame_s = frame_r + FRAME_ONE;
                end
            end else begin
                frame_s = frame_r;
            end
        end else if (act_mode_r == MODE_BLANK) begin
            phase_on_s  = 1'b1;
            frame_s     = '0;
            flash_cnt_s = 3'd0;
        end else begin
            phase_on_s = 1'b1;
            frame_s    = '0;
        end
    end

    // Output drive is computed from the post-tick state so it lands one clk after the tick.
    always_comb begin
        digit_sel_s = digit_sel;
        seg_out_s   = seg_out;
        if (scan_tick) begin
            digit_sel_s = ~(5'b00001 << idx_s);
            if (tick_s < BLANK_END) begin
                seg_out_s = 8'h00;
            end else if (act_mode_s == MODE_BLANK) begin
                seg_out_s = 8'h00;
            end else if ((act_mode_s == MODE_FLASH) && !phase_on_s) begin
                seg_out_s = 8'h00;
            end else begin
                seg_out_s = pick_byte(act_data_s, idx_s);
            end
        end else begin
            digit_sel_s = digit_sel;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r   <= 1'b0;
            tick_r      <= '0;
            idx_r       <= 3'd0;
            pend_data_r <= 40'h0;
            pend_mode_r <= MODE_CONST;
            act_data_r  <= 40'h0;
            act_mode_r  <= MODE_CONST;
            phase_on_r  <= 1'b1;
            frame_r     <= '0;
            flash_cnt   <= 3'd0;
            digit_sel   <= 5'b11111;
            seg_out     <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            running_r   <= running_s;
            tick_r      <= tick_s;
            idx_r       <= idx_s;
            pend_data_r <= pend_data_s;
            pend_mode_r <= pend_mode_s;
            act_data_r  <= act_data_s;
            act_mode_r  <= act_mode_s;
            phase_on_r  <= phase_on_s;
            frame_r     <= frame_s;
            flash_cnt   <= flash_cnt_s;
            digit_sel   <= digit_sel_s;
            seg_out     <= seg_out_s;
            frame_start <= boundary_s;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a tick-count display model queues the expected
// outputs per scan_tick, and a negedge monitor compares them.
module tb_seg_scan;

    localparam int DT      = 4;
    localparam int BT      = 1;
    localparam int FF      = 2;
    localparam int FRAME_T = 5 * DT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scan_tick = 1'b0;
    logic [39:0] data_in = 40'h0;
    logic        data_load = 1'b0;
    logic [2:0]  seg_mode = 3'd0;
    logic [4:0]  digit_sel;
    logic [7:0]  seg_out;
    logic [2:0]  flash_cnt;
    logic        frame_start;

    seg_scan #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT), .FLASH_FRAMES(FF)) dut (
        .clk(clk), .reset(reset), .scan_tick(scan_tick), .data_in(data_in),
        .data_load(data_load), .seg_mode(seg_mode), .digit_sel(digit_sel),
        .seg_out(seg_out), .flash_cnt(flash_cnt), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] ds;
        logic [7:0] seg;
        logic [2:0] fc;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Model: display position derived from the number of ticks since the first one.
    bit          m_started;
    int          m_k;
    logic [39:0] m_pend_d, m_act_d;
    int          m_pend_m, m_act_m;
    bit          m_phase;
    int          m_frames;
    int          m_fcnt;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int norm(input logic [2:0] md);
        return (md == 3'd1) ? 1 : ((md == 3'd2) ? 2 : 0);
    endfunction

    task automatic model_step(input bit tk, input bit ld, input logic [39:0] d,
                              input logic [2:0] md, input bit rs);
        exp_t e;
        bit bnd;
        int dg, w;
        logic [39:0] sh;
        if (rs) begin
            m_started = 0; m_k = 0; m_pend_d = 40'h0; m_pend_m = 0;
            m_act_d = 40'h0; m_act_m = 0; m_phase = 1; m_frames = 0; m_fcnt = 0;
            return;
        end
        bnd = 0;
        if (tk) begin
            if (!m_started) begin
                m_started = 1;
                m_k = 0;
            end else begin
                m_k++;
                bnd = ((m_k % FRAME_T) == 0);
            end
        end
        if (ld) begin
            m_pend_d = d;
            m_pend_m = norm(md);
        end
        if (bnd) begin
            if (m_pend_m != m_act_m) begin
                m_phase = 1; m_frames = 0; m_fcnt = 0;
                m_act_m = m_pend_m;
            end else if (m_act_m == 1) begin
                m_frames++;
                if (m_frames == FF) begin
                    m_frames = 0;
                    m_phase = !m_phase;
                    if (m_phase && m_fcnt < 7) m_fcnt++;
                end
            end
            m_act_d = m_pend_d;
        end
        if (tk) begin
            dg = (m_k / DT) % 5;
            w  = m_k % DT;
            sh = m_act_d >> (8 * (4 - dg));
            e.ds  = ~(5'(1) << dg);
            e.seg = (w < BT || m_act_m == 2 || (m_act_m == 1 && !m_phase)) ? 8'h00 : sh[7:0];
            e.fc  = 3'(m_fcnt);
            e.fs  = bnd;
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input bit tk, input bit ld, input logic [39:0] d,
                       input logic [2:0] md, input bit rs);
        scan_tick = tk; data_load = ld; data_in = d; seg_mode = md; reset = rs;
        model_step(tk, ld, d, md, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            for (int j = 1; j < period; j++) cyc(1'b0, 1'b0, 40'h0, 3'd0, 1'b0);
            cyc(1'b1, 1'b0, 40'h0, 3'd0, 1'b0);
        end
    endtask

    // Advance until the next ticking cycle is a frame boundary.
    task automatic to_boundary();
        for (int i = 0; i < 200 && !(m_started && ((m_k + 1) % FRAME_T == 0)); i++)
            cyc(1'b1, 1'b0, 40'h0, 3'd0, 1'b0);
    endtask

    logic tick_d = 1'b0;
    logic rst_d = 1'b1;
    exp_t last_e = '{ds: 5'b11111, seg: 8'h00, fc: 3'd0, fs: 1'b0};

    always @(posedge clk) begin
        tick_d <= scan_tick && !reset;
        rst_d  <= reset;
    end

    // Monitor: reset values, queued expectations on ticks, and hold between ticks.
    always @(negedge clk) begin
        exp_t e;
        if (rst_d) begin
            chk("rst_digit_sel", 40'(digit_sel), 40'h1F);
            chk("rst_seg_out", 40'(seg_out), 40'h0);
            chk("rst_flash_cnt", 40'(flash_cnt), 40'h0);
            chk("rst_frame_start", 40'(frame_start), 40'h0);
            last_e = '{ds: 5'b11111, seg: 8'h00, fc: 3'd0, fs: 1'b0};
        end else if (tick_d) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 40'(exp_q.size()), 40'h1);
            end else begin
                e = exp_q.pop_front();
                chk("digit_sel", 40'(digit_sel), 40'(e.ds));
                chk("seg_out", 40'(seg_out), 40'(e.seg));
                chk("flash_cnt", 40'(flash_cnt), 40'(e.fc));
                chk("frame_start", 40'(frame_start), 40'(e.fs));
                last_e = e;
            end
        end else begin
            chk("hold_digit_sel", 40'(digit_sel), 40'(last_e.ds));
            chk("hold_seg_out", 40'(seg_out), 40'(last_e.seg));
            chk("hold_flash_cnt", 40'(flash_cnt), 40'(last_e.fc));
            chk("idle_frame_start", 40'(frame_start), 40'h0);
        end
    end

    initial begin
        logic [63:0] rnd;
        model_step(1'b0, 1'b0, 40'h0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 40'h0, 3'd0, 1'b1);
        // idle after release: digit_sel stays dark until the first tick
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 40'h0, 3'd0, 1'b0);

        // constant pattern, visible from the first frame boundary
        cyc(1'b1, 1'b1, 40'h3F_06_5B_4F_66, 3'd0, 1'b0);
        run(3 * FRAME_T, 1);

        // mid-frame load at digit 2
        for (int i = 0; i < 100 && ((m_k / DT) % 5) != 2; i++) cyc(1'b1, 1'b0, 40'h0, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 40'h11_22_33_44_55, 3'd0, 1'b0);
        run(2 * FRAME_T, 1);

        // flash with all segments lit, long enough to saturate flash_cnt
        cyc(1'b1, 1'b1, 40'hFF_FF_FF_FF_FF, 3'd1, 1'b0);
        run(32 * FRAME_T, 1);

        // flash -> constant -> flash, then reload flash while flashing
        cyc(1'b1, 1'b1, 40'hA5_A5_A5_A5_A5, 3'd0, 1'b0);
        run(2 * FRAME_T, 1);
        cyc(1'b1, 1'b1, 40'hFF_FF_FF_FF_FF, 3'd1, 1'b0);
        run(6 * FRAME_T, 1);
        cyc(1'b1, 1'b1, 40'h81_42_24_18_7E, 3'd1, 1'b0);
        run(6 * FRAME_T, 1);

        // load coincident with a frame boundary
        to_boundary();
        cyc(1'b1, 1'b1, 40'hDE_AD_BE_EF_01, 3'd0, 1'b0);
        run(FRAME_T, 1);
        to_boundary();
        cyc(1'b1, 1'b1, 40'hFF_FF_FF_FF_FF, 3'd1, 1'b0);
        run(FRAME_T, 1);

        // reset at digit 3 during an OFF phase, with a load left pending
        cyc(1'b1, 1'b1, 40'h12_34_56_78_9A, 3'd1, 1'b0);
        for (int i = 0; i < 2000 && !(m_act_m == 1 && !m_phase && ((m_k / DT) % 5) == 3); i++)
            cyc(1'b1, 1'b0, 40'h0, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 40'h77_77_77_77_77, 3'd2, 1'b0);
        cyc(1'b1, 1'b0, 40'h0, 3'd0, 1'b1);
        cyc(1'b0, 1'b0, 40'h0, 3'd0, 1'b0);
        run(2 * FRAME_T, 1);

        // slow scan: one tick every third clk
        cyc(1'b1, 1'b1, 40'h3F_06_5B_4F_66, 3'd1, 1'b0);
        run(6 * FRAME_T, 3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rnd = {$urandom, $urandom};
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), rnd[39:0],
                3'($urandom_range(0, 4)), ($urandom_range(0, 699) == 0));
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 40'h0, 3'd0, 1'b0);
        chk("queue_empty", 40'(exp_q.size()), 40'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGIT_TICKS, default 1000: number of scan_tick strobes each digit is held (1 ms at 1 MHz).
REQ-002 Parameter BLANK_TICKS, default 2: number of scan_tick strobes at the start of each digit slot during which seg_out is forced to 0 (anti-ghosting); must be less than DIGIT_TICKS.
REQ-003 Parameter FLASH_FRAMES, default 100: number of 5-digit frames per flash half-period.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 scan_tick  input  1  one-clk strobe, nominally 1 MHz; all timing counts advance only on it.
REQ-007 data_in  input  40  five 8-bit segment codes; [39:32] is digit 0 (leftmost), [7:0] is digit 4; bit 7 is the dp.
REQ-008 data_load  input  1  one-clk strobe; captures data_in and seg_mode.
REQ-009 seg_mode  input  3  3'd0 constant, 3'd1 flash, 3'd2 blank; other codes behave as constant.
REQ-010 digit_sel  output  5  one-hot active-low digit enable; bit n drives digit n.
REQ-011 seg_out  output  8  active-high segment drive for the enabled digit.
REQ-012 flash_cnt  output  3  number of completed flash cycles since the last mode load; saturates at 7.
REQ-013 frame_start  output  1  one-clk pulse when digit index wraps 4->0.

Function
REQ-014 A tick counter shall count scan_tick from 0 to DIGIT_TICKS-1; on the tick at DIGIT_TICKS-1 it returns to 0 and the digit index advances 0->1->2->3->4->0.
REQ-015 digit_sel shall equal ~(5'b00001 << index) and change only on the tick that advances the index; outputs are registered, 1 clk after the tick.
REQ-016 seg_out shall be 0 while the tick counter < BLANK_TICKS, otherwise active byte of the current digit, subject to REQ-019/020.
REQ-017 data_load shall write data_in and seg_mode into a pending register; the active register shall copy pending at each frame boundary (index 4->0 advance).
REQ-018 data_load in the same clk as a frame boundary: active takes data_in and seg_mode directly; pending also updated.
REQ-019 Flash: phase bit starts ON; a frame counter counts frame boundaries; after FLASH_FRAMES boundaries the phase toggles and the counter clears; seg_out is 0 while OFF; digit_sel keeps scanning.
REQ-020 Blank mode: seg_out always 0; digit_sel keeps scanning; flash counters held at 0.
REQ-021 flash_cnt shall increment on every OFF->ON toggle, saturating at 3'd7.
REQ-022 When the active mode changes (at the REQ-017/018 copy), phase shall reset to ON, and the frame counter and flash_cnt to 0; reloading the same mode shall not reset them.
REQ-023 Constant mode shall hold flash_cnt at its last value and force phase ON.
REQ-024 scan_tick held low shall freeze all counters and outputs.
REQ-025 frame_start shall pulse in the clk the active-register copy occurs.

Reset
REQ-026 During reset: digit_sel = 5'b11111, seg_out = 8'h00, flash_cnt = 0, frame_start = 0.
REQ-027 Also during reset: index, tick, and frame counters = 0; active/pending data = 0; mode = constant; phase = ON.
REQ-028 First digit 0 enable shall occur on the first scan_tick after reset release.
REQ-029 Reset asserted mid-slot or mid-flash shall abort immediately; no pending load survives.

Verification (DIGIT_TICKS=4, BLANK_TICKS=1, FLASH_FRAMES=2, scan_tick every clk unless stated)
REQ-030 Load 40'h3F_06_5B_4F_66, constant.
- digit_sel cycles 11110, 11101, 11011, 10111, 01111, 4 ticks each.
- seg_out 00 for 1 tick, then 3F, 06, 5B, 4F, 66 respectively.
REQ-031 Load new data mid-frame (index 2).
- Display unchanged until frame_start.
- New bytes from digit 0 of the next frame; no torn frame.
REQ-032 Flash mode, 0xFF in all digits.
- Non-blank seg_out for 2 frames, 0 for 2 frames, repeating.
- flash_cnt reaches 4 after 4 full cycles (16 frames); saturates at 7.
REQ-033 Flash to constant to flash reload.
- flash_cnt returns to 0 and phase ON at the frame boundary.
- Reloading flash while already in flash leaves flash_cnt untouched.
REQ-034 data_load coincident with frame boundary: new data shown on digit 0 of the frame beginning that clk.
REQ-035 Reset asserted at index 3 during an OFF phase.
- Next clk: digit_sel = 11111, seg_out = 00, flash_cnt = 0.
- After release: digit 0 with data 00, constant mode.
REQ-036 scan_tick every 3rd clk: all slot lengths scale ×3 in clks; outputs never change between ticks.
